// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter that sequences whole-word commands (clear, load16,
// decrement, increment) onto a shared 16-bit byte-loadable register.
module reg_access_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [7:0]  reg_I,
  output logic [1:0]  reg_FunSel,
  output logic        reg_LH,
  output logic        reg_enable,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [1:0]  dbg_state
);

  // Handshake: a command transfers on the cycle reqN_valid && reqN_ready.
  // ready is only ever offered in IDLE to the granted requester; a requester
  // holds op/data stable until it sees ready.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    SINGLE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD16 = 2'b01;
  localparam logic [1:0] FS_LOAD   = 2'b01;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic        grant0, grant1;

  // With both valid, round-robin favours the requester not granted last.
  always_comb begin
    grant1 = req1_valid && (!req0_valid || (RR_EN && !last_q));
    grant0 = req0_valid && !grant1;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    reg_I      = 8'h00;
    reg_FunSel = 2'b00;
    reg_LH     = 1'b0;
    reg_enable = 1'b0;
    done       = 1'b0;
    done_id    = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n && grant0;
        req1_ready = rst_n && grant1;
        if (grant0 || grant1) begin
          op_d    = grant1 ? req1_op : req0_op;
          data_d  = grant1 ? req1_data : req0_data;
          id_d    = grant1;
          last_d  = grant1;
          state_d = ((grant1 ? req1_op : req0_op) == OP_LOAD16) ? LOAD_LO : SINGLE;
        end
      end
      LOAD_LO: begin
        reg_enable = 1'b1;
        reg_FunSel = FS_LOAD;
        reg_I      = data_q[7:0];
        state_d    = LOAD_HI;
      end
      LOAD_HI: begin
        reg_enable = 1'b1;
        reg_FunSel = FS_LOAD;
        reg_LH     = 1'b1;
        reg_I      = data_q[15:8];
        done       = 1'b1;
        done_id    = id_q;
        state_d    = IDLE;
      end
      SINGLE: begin
        reg_enable = 1'b1;
        reg_FunSel = op_q;
        done       = 1'b1;
        done_id    = id_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      data_q  <= 16'h0000;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: one round-robin and one
// fixed-priority instance driven from the same requester inputs.
module tb_reg_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;

  logic        rr_ready0, rr_ready1, rr_LH, rr_en, rr_busy, rr_done, rr_done_id;
  logic [7:0]  rr_I;
  logic [1:0]  rr_fs, rr_state;
  logic        fp_ready0, fp_ready1, fp_LH, fp_en, fp_busy, fp_done, fp_done_id;
  logic [7:0]  fp_I;
  logic [1:0]  fp_fs, fp_state;

  int checks;
  int failures;

  reg_access_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(rr_ready0),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(rr_ready1),
    .reg_I(rr_I), .reg_FunSel(rr_fs), .reg_LH(rr_LH), .reg_enable(rr_en),
    .busy(rr_busy), .done(rr_done), .done_id(rr_done_id), .dbg_state(rr_state)
  );

  reg_access_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(fp_ready0),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(fp_ready1),
    .reg_I(fp_I), .reg_FunSel(fp_fs), .reg_LH(fp_LH), .reg_enable(fp_en),
    .busy(fp_busy), .done(fp_done), .done_id(fp_done_id), .dbg_state(fp_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] op, input logic [15:0] d);
    req0_valid = v; req0_op = op; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [15:0] d);
    req1_valid = v; req1_op = op; req1_data = d;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},   {15'd0, rr_en},   16'd0);
    chk({tag, "_busy"}, {15'd0, rr_busy}, 16'd0);
    chk({tag, "_done"}, {15'd0, rr_done}, 16'd0);
    chk({tag, "_regs"}, {rr_I, 5'd0, rr_fs, rr_LH}, 16'd0);
  endtask

  int rr_dones, fp_dones, fp_r1_seen;
  logic exp_id;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    drive0(1'b1, 2'b01, 16'hAA55);
    drive1(1'b0, 2'b00, 16'h0000);
    repeat (2) tick();

    // reset state, with a valid request already pending
    chk_idle_outputs("rst");
    chk("rst_ready0", {15'd0, rr_ready0}, 16'd0);
    chk("rst_done_id", {15'd0, rr_done_id}, 16'd0);

    // req0 load16 AA55
    rst_n = 1'b1;
    #1;
    chk("ld_ready0", {15'd0, rr_ready0}, 16'd1);
    chk("ld_ready1", {15'd0, rr_ready1}, 16'd0);
    tick();
    drive0(1'b0, 2'b00, 16'h0000);
    chk("ld_lo_ctl", {13'd0, rr_en, rr_fs}, {13'd0, 1'b1, 2'b01});
    chk("ld_lo_byte", {rr_I, 7'd0, rr_LH}, {8'h55, 8'h00});
    chk("ld_lo_done", {15'd0, rr_done}, 16'd0);
    tick();
    chk("ld_hi_byte", {rr_I, 7'd0, rr_LH}, {8'hAA, 8'h01});
    chk("ld_hi_done", {14'd0, rr_done, rr_done_id}, {14'd0, 2'b10});
    tick();
    chk_idle_outputs("ld_end");

    // req1 increment
    drive1(1'b1, 2'b11, 16'hFFFF);
    #1;
    chk("inc_ready1", {14'd0, rr_ready0, rr_ready1}, 16'd1);
    tick();
    drive1(1'b0, 2'b00, 16'h0000);
    chk("inc_single", {rr_I, 4'd0, rr_en, rr_fs, rr_LH}, {8'h00, 4'd0, 1'b1, 2'b11, 1'b0});
    chk("inc_done", {14'd0, rr_done, rr_done_id}, {14'd0, 2'b11});
    tick();
    chk("inc_end_busy", {15'd0, rr_busy}, 16'd0);

    // both valid for 12 cycles: RR alternates 0,1,0,1; FP always grants 0
    drive0(1'b1, 2'b01, 16'h1234);
    drive1(1'b1, 2'b01, 16'h5678);
    rr_dones = 0; fp_dones = 0; fp_r1_seen = 0;
    exp_id = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (fp_ready1) fp_r1_seen++;
      if (rr_done) begin
        chk("rr_done_id", {15'd0, rr_done_id}, {15'd0, exp_id});
        chk("rr_done_byte", {8'd0, rr_I}, exp_id ? 16'h0056 : 16'h0012);
        exp_id = ~exp_id;
        rr_dones++;
      end
      if (fp_done) begin
        chk("fp_done_id", {15'd0, fp_done_id}, 16'd0);
        fp_dones++;
      end
      tick();
    end
    chk("rr_done_count", 16'(rr_dones), 16'd4);
    chk("fp_done_count", 16'(fp_dones), 16'd4);
    chk("fp_ready1_never", 16'(fp_r1_seen), 16'd0);
    drive0(1'b0, 2'b00, 16'h0000);
    drive1(1'b0, 2'b00, 16'h0000);
    tick();

    // reset during LOAD_LO; req0 accepted first leaves the pointer at 0
    drive0(1'b1, 2'b01, 16'hC3C3);
    tick();
    drive0(1'b0, 2'b00, 16'h0000);
    chk("abort_pre_en", {15'd0, rr_en}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    chk("abort_done_id", {15'd0, rr_done_id}, 16'd0);
    tick();
    chk("abort_hold_done", {15'd0, rr_done}, 16'd0);
    rst_n = 1'b1;
    drive0(1'b1, 2'b00, 16'h0000);
    drive1(1'b1, 2'b00, 16'h0000);
    #1;
    chk("post_rst_tie", {14'd0, rr_ready0, rr_ready1}, 16'd2);

    // req1 clear alone, then a tie goes to req0
    drive0(1'b0, 2'b00, 16'h0000);
    #1;
    chk("clr_ready1", {15'd0, rr_ready1}, 16'd1);
    tick();
    chk("clr_single", {rr_I, 4'd0, rr_en, rr_fs, rr_LH}, {8'h00, 4'd0, 1'b1, 2'b00, 1'b0});
    chk("clr_done", {14'd0, rr_done, rr_done_id}, {14'd0, 2'b11});
    tick();
    drive0(1'b1, 2'b01, 16'hBEEF);
    drive1(1'b1, 2'b10, 16'h0000);
    #1;
    chk("tie_after_clr", {14'd0, rr_ready0, rr_ready1}, 16'd2);

    // data changes while busy are ignored
    tick();
    drive0(1'b1, 2'b11, 16'h0000);
    drive1(1'b1, 2'b11, 16'h0000);
    chk("hold_lo", {8'd0, rr_I}, 16'h00EF);
    tick();
    chk("hold_hi", {8'd0, rr_I}, 16'h00BE);
    chk("hold_hi_ctl", {13'd0, rr_fs, rr_LH}, 16'd3);
    tick();
    // back-to-back: pointer now favours req1
    chk("b2b_ready", {14'd0, rr_ready0, rr_ready1}, 16'd1);
    drive0(1'b0, 2'b00, 16'h0000);
    drive1(1'b0, 2'b00, 16'h0000);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Controller that shares one 16-bit byte-loadable register (8-bit I input, FunSel, LH, enable) between two requesters.
- Each requester issues whole-word commands: clear, 16-bit load, decrement, increment.
- The block arbitrates between the requesters and sequences each command into the register's per-cycle controls.
- A 16-bit load becomes two byte-load cycles, low byte then high byte.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 winning.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 command valid.
- req0_op  input  2  requester 0 opcode: 00 clear, 01 load16, 10 decrement, 11 increment.
- req0_data  input  16  requester 0 load value; used only for load16.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req1_valid, req1_op, req1_data, req1_ready: same as requester 0, for requester 1.
- reg_I  output  8  byte driven to the register.
- reg_FunSel  output  2  register function: 00 clear, 01 load byte, 10 decrement, 11 increment.
- reg_LH  output  1  byte select for a byte load: 0 = low, 1 = high.
- reg_enable  output  1  register update enable.
- busy  output  1  a command is in progress (state not IDLE).
- done  output  1  one-cycle pulse in the last register-update cycle of a command.
- done_id  output  1  requester that owns the command signalled by done.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state IDLE;
  - last-grant pointer = 1, so requester 0 wins the first tie;
  - all outputs 0 (reg_I 8'h00, reg_FunSel 00, reg_LH 0, reg_enable 0, busy 0, done 0, done_id 0, both ready 0);
  - latched command cleared.
- Reset mid-command: the command is aborted with no done pulse, and reg_enable drops immediately.
- FSM states: IDLE, LOAD_LO, LOAD_HI, SINGLE.
- IDLE:
  - readyN is combinational: asserted only in IDLE, only for the granted requester, only when its valid is high.
  - Handshake on readyN && reqN_valid: latch op, data and id, then go to LOAD_LO if op = 01, else to SINGLE.
  - reg_enable = 0 in IDLE.
- Arbitration, evaluated in IDLE only:
  - one valid requester: it is granted;
  - both valid with RR_EN = 1: grant the requester not granted last; the pointer updates on each accept;
  - both valid with RR_EN = 0: grant requester 0 always.
- LOAD_LO: reg_enable 1, reg_FunSel 01, reg_LH 0, reg_I = data[7:0]. Next state LOAD_HI.
- LOAD_HI: reg_enable 1, reg_FunSel 01, reg_LH 1, reg_I = data[15:8]; done = 1. Next state IDLE.
- SINGLE: reg_enable 1, reg_FunSel = latched op, reg_LH 0, reg_I 8'h00; done = 1. Next state IDLE.
- Output decoding: register outputs, done and busy are Moore outputs decoded from state and the latched command. They are held stable for the full cycle.
- Latency from accept edge to register update:
  - load16 takes 3 cycles including IDLE; the register is written on the edges ending LOAD_LO and LOAD_HI;
  - clear, decrement and increment take 2 cycles.
- No command is accepted while busy. A valid requester holds its command until ready; changes to req inputs while busy are ignored.
- Back-to-back: a new accept is possible in the IDLE cycle right after done.

Test Plan:
- Reset then req0 load16 16'hAA55: req0_ready high in cycle 0. Cycle 1: reg_enable 1, FunSel 01, LH 0, I 8'h55. Cycle 2: LH 1, I 8'hAA, done 1, done_id 0. Cycle 3: busy 0.
- req1 increment: one SINGLE cycle with FunSel 11, enable 1, I 8'h00, done 1, done_id 1.
- Both requesters valid continuously with RR_EN = 1: grants alternate 0,1,0,1; each is a load16 taking 3 cycles, so 12 cycles yield 4 done pulses.
- RR_EN = 0, both valid continuously: requester 0 granted every time; req1_ready never asserted.
- Assert rst_n low during LOAD_LO:
  - all outputs are 0 immediately, with no done pulse;
  - after release, a req1 clear is accepted;
  - a tie is then granted per the reset pointer (requester 0 first).
- Change req0_data while busy: the LOAD_HI byte still equals the value latched at accept.
